// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundle between the multicycle MIPS controller and its datapath.
//
//   Status (datapath -> controller):
//     opcode[5:0], funct[5:0]  decoded IR fields
//     zero, overflow           ALU flags
//     div_zero, md_done        mult/div unit status
//   Control (controller -> datapath):
//     pc_write, ir_write, mem_write, a_write, b_write, aluout_write,
//     epc_write, hi_write, lo_write, bank_write   register write enables
//     iord, pc_source, alu_src_a, alu_src_b       mux selects
//     alu_op, bank_write_reg, bank_write_data     ALU op / regfile write selects
//     load_ctrl                                   load width
//     md_start, md_op                             mult/div handshake
//
//   Modports: master = controller, slave = datapath.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       div_zero;
  logic       md_done;

  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       a_write;
  logic       b_write;
  logic       aluout_write;
  logic       epc_write;
  logic       hi_write;
  logic       lo_write;
  logic       bank_write;
  logic [2:0] iord;
  logic [2:0] pc_source;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [2:0] bank_write_reg;
  logic [2:0] bank_write_data;
  logic [1:0] load_ctrl;
  logic       md_start;
  logic       md_op;

  modport master (
    input  opcode, funct, zero, overflow, div_zero, md_done,
    output pc_write, ir_write, mem_write, a_write, b_write, aluout_write,
           epc_write, hi_write, lo_write, bank_write, iord, pc_source,
           alu_src_a, alu_src_b, alu_op, bank_write_reg, bank_write_data,
           load_ctrl, md_start, md_op
  );

  modport slave (
    output opcode, funct, zero, overflow, div_zero, md_done,
    input  pc_write, ir_write, mem_write, a_write, b_write, aluout_write,
           epc_write, hi_write, lo_write, bank_write, iord, pc_source,
           alu_src_a, alu_src_b, alu_op, bank_write_reg, bank_write_data,
           load_ctrl, md_start, md_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Moore FSM sequencing the multicycle MIPS datapath: fetch, decode,
//   R-type / addi / lw / sw / beq / j / rte, and exception entry through a
//   handler vector read from memory.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; all controls read 0 while it is high
//     bus    multicycle_ctrl_if.master (status in, control out)
//
//   The constants the controller selects live in the datapath:
//     SP_INIT  = 227 written to $29 out of reset (bank_write_data = 7)
//     VEC_OPC  = 253 invalid-opcode handler address (iord = 2)
//     VEC_OVF  = 254 overflow handler address       (iord = 3)
//     VEC_DIV0 = 255 divide-by-zero handler address (iord = 4)
//
//   Build option: define MULTDIV_EN to enable mult/div/mfhi/mflo; without it
//   those functs take the invalid-opcode path and md_start, md_op,
//   hi_write, lo_write stay 0.
// ---------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_FETCH_W, S_DECODE, S_EXEC_R, S_WB_R, S_RTE,
    S_ADDI, S_WB_I, S_MEM_ADDR, S_LW_RD, S_LW_WAIT, S_LW_WB, S_SW,
    S_BEQ, S_J, S_EXC_SAVE, S_EXC_RD, S_EXC_WAIT, S_EXC_JUMP,
    S_MD_START, S_MD_WAIT, S_MD_WR, S_WB_HL
  } state_e;

  // Exception cause; iord for the handler fetch is 2 + cause.
  typedef enum logic [1:0] {
    VSEL_OPC  = 2'd0,
    VSEL_OVF  = 2'd1,
    VSEL_DIV0 = 2'd2
  } vec_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       epc_write;
    logic       hi_write;
    logic       lo_write;
    logic       bank_write;
    logic [2:0] iord;
    logic [2:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] bank_write_reg;
    logic [2:0] bank_write_data;
    logic [1:0] load_ctrl;
    logic       md_start;
    logic       md_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_RTE   = 6'h13;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
`ifdef MULTDIV_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
`endif

  state_e state_q, state_d;
  vec_e   vec_q, vec_d;
  ctrl_t  c;

  logic fn_arith;  // add/sub: the R-type ops that can overflow
  logic fn_alu;    // add/sub/and: handled by EXEC_R
  assign fn_arith = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);
  assign fn_alu   = fn_arith || (bus.funct == FN_AND);

`ifdef MULTDIV_EN
  logic fn_div, fn_md, fn_hl;
  assign fn_div = (bus.funct == FN_DIV);
  assign fn_md  = (bus.funct == FN_MULT) || fn_div;
  assign fn_hl  = (bus.funct == FN_MFHI) || (bus.funct == FN_MFLO);
`else
  logic unused_md_inputs;
  assign unused_md_inputs = bus.div_zero ^ bus.md_done;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_RST;
      vec_q   <= VSEL_OPC;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    c       = '0;
    state_d = state_q;
    vec_d   = vec_q;

    // While reset is high every control stays 0, so an aborted instruction
    // cannot write anything at the reset edge.
    if (!reset) begin
      case (state_q)
        S_RST: begin
          c.bank_write      = 1'b1;
          c.bank_write_reg  = 3'd4;
          c.bank_write_data = 3'd7;
          state_d           = S_FETCH;
        end

        S_FETCH: begin
          c.alu_src_b = 2'd1;
          c.alu_op    = 3'd1;
          c.pc_write  = 1'b1;
          state_d     = S_FETCH_W;
        end

        S_FETCH_W: begin
          c.ir_write = 1'b1;
          state_d    = S_DECODE;
        end

        S_DECODE: begin
          // Speculatively compute the branch target into ALUout.
          c.a_write      = 1'b1;
          c.b_write      = 1'b1;
          c.alu_src_b    = 2'd3;
          c.alu_op       = 3'd1;
          c.aluout_write = 1'b1;
          state_d        = S_EXC_SAVE;
          vec_d          = VSEL_OPC;
          case (bus.opcode)
            OP_RTYPE: begin
              if (fn_alu)                   state_d = S_EXEC_R;
              else if (bus.funct == FN_RTE) state_d = S_RTE;
`ifdef MULTDIV_EN
              else if (fn_md)               state_d = S_MD_START;
              else if (fn_hl)               state_d = S_WB_HL;
`endif
            end
            OP_ADDI:      state_d = S_ADDI;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_J;
            default:      state_d = S_EXC_SAVE;
          endcase
        end

        S_EXEC_R: begin
          c.alu_src_a    = 2'd2;
          c.aluout_write = 1'b1;
          case (bus.funct)
            FN_SUB:  c.alu_op = 3'd2;
            FN_AND:  c.alu_op = 3'd3;
            default: c.alu_op = 3'd1;
          endcase
          // Invalid opcode outranks overflow.
          if (!fn_alu) begin
            state_d = S_EXC_SAVE;
            vec_d   = VSEL_OPC;
          end else if (bus.overflow && fn_arith) begin
            state_d = S_EXC_SAVE;
            vec_d   = VSEL_OVF;
          end else begin
            state_d = S_WB_R;
          end
        end

        S_WB_R: begin
          c.bank_write     = 1'b1;
          c.bank_write_reg = 3'd1;
          state_d          = S_FETCH;
        end

        S_RTE: begin
          c.pc_source = 3'd3;
          c.pc_write  = 1'b1;
          state_d     = S_FETCH;
        end

        S_ADDI: begin
          c.alu_src_a    = 2'd2;
          c.alu_src_b    = 2'd2;
          c.alu_op       = 3'd1;
          c.aluout_write = 1'b1;
          if (bus.overflow) begin
            state_d = S_EXC_SAVE;
            vec_d   = VSEL_OVF;
          end else begin
            state_d = S_WB_I;
          end
        end

        S_WB_I: begin
          c.bank_write = 1'b1;
          state_d      = S_FETCH;
        end

        S_MEM_ADDR: begin
          c.alu_src_a    = 2'd2;
          c.alu_src_b    = 2'd2;
          c.alu_op       = 3'd1;
          c.aluout_write = 1'b1;
          state_d        = (bus.opcode == OP_LW) ? S_LW_RD : S_SW;
        end

        S_LW_RD: begin
          c.iord  = 3'd1;
          state_d = S_LW_WAIT;
        end

        S_LW_WAIT: begin
          c.iord  = 3'd1;
          state_d = S_LW_WB;
        end

        S_LW_WB: begin
          c.bank_write      = 1'b1;
          c.bank_write_data = 3'd1;
          state_d           = S_FETCH;
        end

        S_SW: begin
          c.iord      = 3'd1;
          c.mem_write = 1'b1;
          state_d     = S_FETCH;
        end

        S_BEQ: begin
          c.alu_src_a = 2'd2;
          c.alu_op    = 3'd2;
          c.pc_source = 3'd1;
          c.pc_write  = bus.zero;
          state_d     = S_FETCH;
        end

        S_J: begin
          c.pc_source = 3'd2;
          c.pc_write  = 1'b1;
          state_d     = S_FETCH;
        end

        S_EXC_SAVE: begin
          // PC already advanced in FETCH; EPC gets PC - 4.
          c.alu_src_b = 2'd1;
          c.alu_op    = 3'd2;
          c.epc_write = 1'b1;
          state_d     = S_EXC_RD;
        end

        S_EXC_RD: begin
          c.iord  = 3'd2 + {1'b0, vec_q};
          state_d = S_EXC_WAIT;
        end

        S_EXC_WAIT: begin
          c.iord  = 3'd2 + {1'b0, vec_q};
          state_d = S_EXC_JUMP;
        end

        S_EXC_JUMP: begin
          c.load_ctrl = 2'd2;
          c.pc_source = 3'd4;
          c.pc_write  = 1'b1;
          state_d     = S_FETCH;
        end

`ifdef MULTDIV_EN
        S_MD_START: begin
          c.md_start = 1'b1;
          c.md_op    = fn_div;
          if (fn_div && bus.div_zero) begin
            state_d = S_EXC_SAVE;
            vec_d   = VSEL_DIV0;
          end else begin
            state_d = S_MD_WAIT;
          end
        end

        S_MD_WAIT: begin
          c.md_op = fn_div;
          if (bus.md_done) state_d = S_MD_WR;
        end

        S_MD_WR: begin
          c.hi_write = 1'b1;
          c.lo_write = 1'b1;
          state_d    = S_FETCH;
        end

        S_WB_HL: begin
          c.bank_write      = 1'b1;
          c.bank_write_reg  = 3'd1;
          c.bank_write_data = (bus.funct == FN_MFHI) ? 3'd3 : 3'd4;
          state_d           = S_FETCH;
        end
`endif

        default: state_d = S_RST;
      endcase
    end
  end

  assign bus.pc_write        = c.pc_write;
  assign bus.ir_write        = c.ir_write;
  assign bus.mem_write       = c.mem_write;
  assign bus.a_write         = c.a_write;
  assign bus.b_write         = c.b_write;
  assign bus.aluout_write    = c.aluout_write;
  assign bus.epc_write       = c.epc_write;
  assign bus.hi_write        = c.hi_write;
  assign bus.lo_write        = c.lo_write;
  assign bus.bank_write      = c.bank_write;
  assign bus.iord            = c.iord;
  assign bus.pc_source       = c.pc_source;
  assign bus.alu_src_a       = c.alu_src_a;
  assign bus.alu_src_b       = c.alu_src_b;
  assign bus.alu_op          = c.alu_op;
  assign bus.bank_write_reg  = c.bank_write_reg;
  assign bus.bank_write_data = c.bank_write_data;
  assign bus.load_ctrl       = c.load_ctrl;
  assign bus.md_start        = c.md_start;
  assign bus.md_op           = c.md_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. A per-cycle table of
//   {reset, status inputs, expected controls} walks whole instructions;
//   hand-written sequences cover exception pulse counting and, with
//   MULTDIV_EN, the mult/div handshake and reset during MD_WAIT.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       epc_write;
    logic       hi_write;
    logic       lo_write;
    logic       bank_write;
    logic [2:0] iord;
    logic [2:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] bank_write_reg;
    logic [2:0] bank_write_data;
    logic [1:0] load_ctrl;
    logic       md_start;
    logic       md_op;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ovf;
    logic       dz;
    logic       done;
    ctl_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  vec_t vq[$];

  ctl_t C_ZERO, C_RST, C_FETCH, C_FETCH_W, C_DECODE;
  ctl_t C_EX_ADD, C_EX_SUB, C_EX_AND, C_WB_R, C_RTE, C_ADDI, C_WB_I;
  ctl_t C_MEM_ADDR, C_LW_RD, C_LW_WB, C_SW, C_BEQ_T, C_BEQ_N, C_J;
  ctl_t C_EXC_SAVE, C_IORD2, C_IORD3, C_IORD4, C_EXC_JUMP;
  ctl_t C_MD_START_DIV, C_MD_WAIT_DIV, C_MD_WR, C_WB_HI, C_WB_LO;

  task automatic init_consts();
    C_ZERO = '0;
    C_RST = '0; C_RST.bank_write = 1; C_RST.bank_write_reg = 3'd4; C_RST.bank_write_data = 3'd7;
    C_FETCH = '0; C_FETCH.alu_src_b = 2'd1; C_FETCH.alu_op = 3'd1; C_FETCH.pc_write = 1;
    C_FETCH_W = '0; C_FETCH_W.ir_write = 1;
    C_DECODE = '0; C_DECODE.a_write = 1; C_DECODE.b_write = 1; C_DECODE.alu_src_b = 2'd3;
    C_DECODE.alu_op = 3'd1; C_DECODE.aluout_write = 1;
    C_EX_ADD = '0; C_EX_ADD.alu_src_a = 2'd2; C_EX_ADD.alu_op = 3'd1; C_EX_ADD.aluout_write = 1;
    C_EX_SUB = C_EX_ADD; C_EX_SUB.alu_op = 3'd2;
    C_EX_AND = C_EX_ADD; C_EX_AND.alu_op = 3'd3;
    C_WB_R = '0; C_WB_R.bank_write = 1; C_WB_R.bank_write_reg = 3'd1;
    C_RTE = '0; C_RTE.pc_source = 3'd3; C_RTE.pc_write = 1;
    C_ADDI = '0; C_ADDI.alu_src_a = 2'd2; C_ADDI.alu_src_b = 2'd2; C_ADDI.alu_op = 3'd1;
    C_ADDI.aluout_write = 1;
    C_WB_I = '0; C_WB_I.bank_write = 1;
    C_MEM_ADDR = C_ADDI;
    C_LW_RD = '0; C_LW_RD.iord = 3'd1;
    C_LW_WB = '0; C_LW_WB.bank_write = 1; C_LW_WB.bank_write_data = 3'd1;
    C_SW = '0; C_SW.iord = 3'd1; C_SW.mem_write = 1;
    C_BEQ_N = '0; C_BEQ_N.alu_src_a = 2'd2; C_BEQ_N.alu_op = 3'd2; C_BEQ_N.pc_source = 3'd1;
    C_BEQ_T = C_BEQ_N; C_BEQ_T.pc_write = 1;
    C_J = '0; C_J.pc_source = 3'd2; C_J.pc_write = 1;
    C_EXC_SAVE = '0; C_EXC_SAVE.alu_src_b = 2'd1; C_EXC_SAVE.alu_op = 3'd2; C_EXC_SAVE.epc_write = 1;
    C_IORD2 = '0; C_IORD2.iord = 3'd2;
    C_IORD3 = '0; C_IORD3.iord = 3'd3;
    C_IORD4 = '0; C_IORD4.iord = 3'd4;
    C_EXC_JUMP = '0; C_EXC_JUMP.load_ctrl = 2'd2; C_EXC_JUMP.pc_source = 3'd4; C_EXC_JUMP.pc_write = 1;
    C_MD_START_DIV = '0; C_MD_START_DIV.md_start = 1; C_MD_START_DIV.md_op = 1;
    C_MD_WAIT_DIV = '0; C_MD_WAIT_DIV.md_op = 1;
    C_MD_WR = '0; C_MD_WR.hi_write = 1; C_MD_WR.lo_write = 1;
    C_WB_HI = C_WB_R; C_WB_HI.bank_write_data = 3'd3;
    C_WB_LO = C_WB_R; C_WB_LO.bank_write_data = 3'd4;
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.pc_write        = bus.pc_write;
    s.ir_write        = bus.ir_write;
    s.mem_write       = bus.mem_write;
    s.a_write         = bus.a_write;
    s.b_write         = bus.b_write;
    s.aluout_write    = bus.aluout_write;
    s.epc_write       = bus.epc_write;
    s.hi_write        = bus.hi_write;
    s.lo_write        = bus.lo_write;
    s.bank_write      = bus.bank_write;
    s.iord            = bus.iord;
    s.pc_source       = bus.pc_source;
    s.alu_src_a       = bus.alu_src_a;
    s.alu_src_b       = bus.alu_src_b;
    s.alu_op          = bus.alu_op;
    s.bank_write_reg  = bus.bank_write_reg;
    s.bank_write_data = bus.bank_write_data;
    s.load_ctrl       = bus.load_ctrl;
    s.md_start        = bus.md_start;
    s.md_op           = bus.md_op;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic row(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ovf, input logic dz, input logic done,
                     input ctl_t e);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.ovf = ovf; v.dz = dz; v.done = done; v.exp = e;
    vq.push_back(v);
  endtask

  // FETCH, FETCH_W, DECODE for one instruction.
  task automatic pro(input logic [5:0] op, input logic [5:0] fn);
    row(0, op, fn, 0, 0, 0, 0, C_FETCH);
    row(0, op, fn, 0, 0, 0, 0, C_FETCH_W);
    row(0, op, fn, 0, 0, 0, 0, C_DECODE);
  endtask

  // Exception tail after the cause cycle: save, two vector reads, jump.
  task automatic exc_tail(input logic [5:0] op, input logic [5:0] fn, input ctl_t iord_c);
    row(0, op, fn, 0, 0, 0, 0, C_EXC_SAVE);
    row(0, op, fn, 0, 0, 0, 0, iord_c);
    row(0, op, fn, 0, 0, 0, 0, iord_c);
    row(0, op, fn, 0, 0, 0, 0, C_EXC_JUMP);
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ovf, input logic dz, input logic done);
    reset = r; bus.opcode = op; bus.funct = fn; bus.zero = z;
    bus.overflow = ovf; bus.div_zero = dz; bus.md_done = done;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the RST cycle with reset low.
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    ctl_t s;
    int   epc_n, iord2_n, starts, hl_n, mdop_n;

    init_consts();

    // ---- table ----
    row(1, 0, 0, 0, 0, 0, 0, C_ZERO);
    row(1, 0, 0, 0, 0, 0, 0, C_ZERO);
    row(0, 0, 0, 0, 0, 0, 0, C_RST);
    // add, no overflow
    pro(6'h00, 6'h20);
    row(0, 6'h00, 6'h20, 0, 0, 0, 0, C_EX_ADD);
    row(0, 6'h00, 6'h20, 0, 0, 0, 0, C_WB_R);
    // beq taken, then not taken
    pro(6'h04, 0);
    row(0, 6'h04, 0, 1, 0, 0, 0, C_BEQ_T);
    pro(6'h04, 0);
    row(0, 6'h04, 0, 0, 0, 0, 0, C_BEQ_N);
    // addi with overflow -> VEC_OVF
    pro(6'h08, 0);
    row(0, 6'h08, 0, 0, 1, 0, 0, C_ADDI);
    exc_tail(6'h08, 0, C_IORD3);
    // addi without overflow
    pro(6'h08, 0);
    row(0, 6'h08, 0, 0, 0, 0, 0, C_ADDI);
    row(0, 6'h08, 0, 0, 0, 0, 0, C_WB_I);
    // invalid opcode 0x3F -> VEC_OPC straight from DECODE
    pro(6'h3F, 0);
    exc_tail(6'h3F, 0, C_IORD2);
    // sub with overflow -> VEC_OVF
    pro(6'h00, 6'h22);
    row(0, 6'h00, 6'h22, 0, 1, 0, 0, C_EX_SUB);
    exc_tail(6'h00, 6'h22, C_IORD3);
    // and ignores overflow
    pro(6'h00, 6'h24);
    row(0, 6'h00, 6'h24, 0, 1, 0, 0, C_EX_AND);
    row(0, 6'h00, 6'h24, 0, 0, 0, 0, C_WB_R);
    // lw
    pro(6'h23, 0);
    row(0, 6'h23, 0, 0, 0, 0, 0, C_MEM_ADDR);
    row(0, 6'h23, 0, 0, 0, 0, 0, C_LW_RD);
    row(0, 6'h23, 0, 0, 0, 0, 0, C_LW_RD);
    row(0, 6'h23, 0, 0, 0, 0, 0, C_LW_WB);
    // sw
    pro(6'h2B, 0);
    row(0, 6'h2B, 0, 0, 0, 0, 0, C_MEM_ADDR);
    row(0, 6'h2B, 0, 0, 0, 0, 0, C_SW);
    // j, rte
    pro(6'h02, 0);
    row(0, 6'h02, 0, 0, 0, 0, 0, C_J);
    pro(6'h00, 6'h13);
    row(0, 6'h00, 6'h13, 0, 0, 0, 0, C_RTE);
    // unknown funct
    pro(6'h00, 6'h3F);
    exc_tail(6'h00, 6'h3F, C_IORD2);
`ifdef MULTDIV_EN
    pro(6'h00, 6'h10);
    row(0, 6'h00, 6'h10, 0, 0, 0, 0, C_WB_HI);
    pro(6'h00, 6'h12);
    row(0, 6'h00, 6'h12, 0, 0, 0, 0, C_WB_LO);
`else
    // mult without the option is an invalid instruction
    pro(6'h00, 6'h18);
    exc_tail(6'h00, 6'h18, C_IORD2);
`endif
    // reset in EXEC_R aborts the add without a write-back
    pro(6'h00, 6'h20);
    row(1, 6'h00, 6'h20, 0, 0, 0, 0, C_ZERO);
    row(0, 6'h00, 6'h20, 0, 0, 0, 0, C_RST);
    row(0, 6'h00, 6'h20, 0, 0, 0, 0, C_FETCH);

    #1;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].op, vq[i].fn, vq[i].z, vq[i].ovf, vq[i].dz, vq[i].done);
      #1;
      check($sformatf("row%0d", i), 64'(sample()), 64'(vq[i].exp));
      step();
    end

    // ---- invalid opcode: epc_write exactly once, iord=2 twice ----
    do_reset();
    bus.opcode = 6'h3F;
    epc_n = 0; iord2_n = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      s = sample();
      if (s.epc_write) epc_n++;
      if (s.iord == 3'd2) iord2_n++;
    end
    check("epc_pulses", 64'(epc_n), 64'd1);
    check("iord2_cycles", 64'(iord2_n), 64'd2);

`ifdef MULTDIV_EN
    // ---- div, divisor non-zero, md_done after 32 wait cycles ----
    do_reset();
    drive(0, 6'h00, 6'h1A, 0, 0, 0, 0);
    step(); step(); step();              // FETCH, FETCH_W, DECODE
    starts = 0; hl_n = 0; mdop_n = 0;
    for (int k = 0; k < 33; k++) begin   // MD_START then 32 x MD_WAIT
      step();
      s = sample();
      if (s.md_start) starts++;
      if (s.hi_write || s.lo_write) hl_n++;
      if (s.md_op) mdop_n++;
      if (k == 32) bus.md_done = 1'b1;
    end
    check("md_start_pulses", 64'(starts), 64'd1);
    check("hilo_before_done", 64'(hl_n), 64'd0);
    check("md_op_held", 64'(mdop_n), 64'd33);
    step();
    bus.md_done = 1'b0;
    #1;
    check("md_wr", 64'(sample()), 64'(C_MD_WR));
    step();
    check("md_after_fetch", 64'(sample()), 64'(C_FETCH));

    // ---- div by zero -> VEC_DIV0, no HI/LO write ----
    do_reset();
    drive(0, 6'h00, 6'h1A, 0, 0, 1, 0);
    step(); step(); step();
    step(); check("div0_start", 64'(sample()), 64'(C_MD_START_DIV));
    step(); check("div0_save", 64'(sample()), 64'(C_EXC_SAVE));
    step(); check("div0_rd", 64'(sample()), 64'(C_IORD4));
    step(); check("div0_wait", 64'(sample()), 64'(C_IORD4));
    step(); check("div0_jump", 64'(sample()), 64'(C_EXC_JUMP));

    // ---- reset in MD_WAIT with md_done in the same cycle ----
    do_reset();
    drive(0, 6'h00, 6'h1A, 0, 0, 0, 0);
    step(); step(); step(); step();      // ... MD_START
    step(); step();                      // MD_WAIT x2
    check("mdwait_div", 64'(sample()), 64'(C_MD_WAIT_DIV));
    reset = 1'b1;
    bus.md_done = 1'b1;
    #1;
    check("mdwait_reset_zero", 64'(sample()), 64'(C_ZERO));
    step();
    reset = 1'b0;
    bus.md_done = 1'b0;
    #1;
    check("mdwait_reset_rst", 64'(sample()), 64'(C_RST));
    step();
    check("mdwait_reset_fetch", 64'(sample()), 64'(C_FETCH));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
